// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: lane-split bitwise/popcount stage with a stallable,
// valid-tracked register pipeline and per-lane zero flags.
//   op_mode 00: per-bit truth-table lookup, result[k] = op_lut[{A[k],B[k]}]
//   op_mode 01: adder result passed through untouched
//   op_mode 10: operand A passed through
//   op_mode 11: per-lane popcount of A, zero-extended to the lane width
// WORD_WIDTH must be a multiple of LANES, and PIPE_DEPTH must be at least 1.
module logic_unit_pipe #(
    parameter int WORD_WIDTH = 36,
    parameter int LANES      = 1,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic [1:0]            op_mode,
    input  logic [3:0]            op_lut,
    input  logic [WORD_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] B,
    input  logic [WORD_WIDTH-1:0] result_add_sub,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] R,
    output logic [LANES-1:0]      zero_flags
);

    localparam int LANE_WIDTH = WORD_WIDTH / LANES;

    typedef enum logic [1:0] {
        MODE_LUT     = 2'b00,
        MODE_ADD_SUB = 2'b01,
        MODE_PASS_A  = 2'b10,
        MODE_POPCNT  = 2'b11
    } mode_t;

    logic [WORD_WIDTH-1:0] result;
    logic [LANES-1:0]      result_flags;
    logic [LANE_WIDTH-1:0] lane_count;

    logic [WORD_WIDTH-1:0] stage_data  [PIPE_DEPTH];
    logic [LANES-1:0]      stage_flags [PIPE_DEPTH];
    logic                  stage_valid [PIPE_DEPTH];

    // Combinational result selected by the operating mode.
    always_comb begin
        result     = '0;
        lane_count = '0;
        case (mode_t'(op_mode))
            MODE_LUT: begin
                for (int k = 0; k < WORD_WIDTH; k++) begin
                    result[k] = op_lut[{A[k], B[k]}];
                end
            end
            MODE_ADD_SUB: result = result_add_sub;
            MODE_PASS_A:  result = A;
            MODE_POPCNT: begin
                for (int i = 0; i < LANES; i++) begin
                    lane_count = '0;
                    for (int b = 0; b < LANE_WIDTH; b++) begin
                        lane_count = lane_count + LANE_WIDTH'(A[i*LANE_WIDTH + b]);
                    end
                    result[i*LANE_WIDTH +: LANE_WIDTH] = lane_count;
                end
            end
            default: result = '0;
        endcase
    end

    // Per-lane zero detection on the freshly computed result.
    always_comb begin
        result_flags = '0;
        for (int i = 0; i < LANES; i++) begin
            result_flags[i] = (result[i*LANE_WIDTH +: LANE_WIDTH] == '0);
        end
    end

    // Pipeline: valid bits always advance, data/flags load only behind a valid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                stage_data[s]  <= '0;
                stage_flags[s] <= '0;
                stage_valid[s] <= 1'b0;
            end
        end else if (!stall) begin
            stage_valid[0] <= in_valid;
            if (in_valid) begin
                stage_data[0]  <= result;
                stage_flags[0] <= result_flags;
            end
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                stage_valid[s] <= stage_valid[s-1];
                if (stage_valid[s-1]) begin
                    stage_data[s]  <= stage_data[s-1];
                    stage_flags[s] <= stage_flags[s-1];
                end
            end
        end
    end

    assign out_valid  = stage_valid[PIPE_DEPTH-1];
    assign R          = stage_data[PIPE_DEPTH-1];
    assign zero_flags = stage_flags[PIPE_DEPTH-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe (36 bits, 4 lanes,
// 3 stages). A posedge process records every accepted input with its expected
// result and the advancing-edge count at which it must emerge; a negedge
// monitor pops and compares, and checks hold behaviour on bubbles and stalls.
module tb_logic_unit_pipe;

    localparam int WW = 36;
    localparam int NL = 4;
    localparam int LW = WW / NL;
    localparam int D  = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          stall;
    logic [1:0]    op_mode;
    logic [3:0]    op_lut;
    logic [WW-1:0] A;
    logic [WW-1:0] B;
    logic [WW-1:0] result_add_sub;
    logic          out_valid;
    logic [WW-1:0] R;
    logic [NL-1:0] zero_flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WW-1:0] r;
        logic [NL-1:0] f;
        int            due;
    } exp_t;

    exp_t sb[$];

    typedef enum int { EK_NONE, EK_RESET, EK_ADV, EK_STALL } edge_kind_t;
    edge_kind_t    edge_kind = EK_NONE;
    int            adv_count = 0;
    logic          exp_ov    = 1'b0;
    logic [WW-1:0] last_r    = '0;
    logic [NL-1:0] last_f    = '0;

    logic_unit_pipe #(.WORD_WIDTH(WW), .LANES(NL), .PIPE_DEPTH(D)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .stall          (stall),
        .op_mode        (op_mode),
        .op_lut         (op_lut),
        .A              (A),
        .B              (B),
        .result_add_sub (result_add_sub),
        .out_valid      (out_valid),
        .R              (R),
        .zero_flags     (zero_flags)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] pk(input logic ov, input logic [NL-1:0] f, input logic [WW-1:0] r);
        return {23'd0, ov, f, r};
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: LUT as a sum of minterms, popcount via $countones per lane.
    function automatic logic [WW-1:0] ref_result(input logic [1:0] mode, input logic [3:0] lut,
                                                  input logic [WW-1:0] a, input logic [WW-1:0] b,
                                                  input logic [WW-1:0] as);
        logic [WW-1:0] r;
        r = '0;
        if (mode == 2'b00) begin
            r = ({WW{lut[3]}} & a & b) | ({WW{lut[2]}} & a & ~b) |
                ({WW{lut[1]}} & ~a & b) | ({WW{lut[0]}} & ~a & ~b);
        end else if (mode == 2'b01) begin
            r = as;
        end else if (mode == 2'b10) begin
            r = a;
        end else begin
            for (int i = 0; i < NL; i++) begin
                r[i*LW +: LW] = LW'($countones(a[i*LW +: LW]));
            end
        end
        return r;
    endfunction

    function automatic logic [NL-1:0] ref_flags(input logic [WW-1:0] r);
        logic [NL-1:0] f;
        f = '0;
        for (int i = 0; i < NL; i++) begin
            f[i] = (r[i*LW +: LW] == '0);
        end
        return f;
    endfunction

    // Model side: classify each edge and queue expectations for accepted inputs.
    always @(posedge clock) begin
        exp_t e;
        if (!reset_n) begin
            edge_kind = EK_RESET;
            sb.delete();
        end else if (stall) begin
            edge_kind = EK_STALL;
        end else begin
            edge_kind = EK_ADV;
            adv_count++;
            if (in_valid) begin
                e.r   = ref_result(op_mode, op_lut, A, B, result_add_sub);
                e.f   = ref_flags(e.r);
                e.due = adv_count + D - 1;
                sb.push_back(e);
            end
        end
    end

    // Monitor: pop on new results, otherwise require the outputs to hold.
    always @(negedge clock) begin
        exp_t e;
        case (edge_kind)
            EK_RESET: begin
                compare("reset_state", pk(out_valid, zero_flags, R), pk(1'b0, '0, '0));
                exp_ov = 1'b0;
                last_r = '0;
                last_f = '0;
            end
            EK_ADV: begin
                if (sb.size() > 0 && sb[0].due == adv_count) begin
                    e = sb.pop_front();
                    compare("result", pk(out_valid, zero_flags, R), pk(1'b1, e.f, e.r));
                    exp_ov = 1'b1;
                    last_r = e.r;
                    last_f = e.f;
                end else begin
                    compare("bubble_hold", pk(out_valid, zero_flags, R), pk(1'b0, last_f, last_r));
                    exp_ov = 1'b0;
                end
            end
            EK_STALL: begin
                compare("stall_hold", pk(out_valid, zero_flags, R), pk(exp_ov, last_f, last_r));
            end
            default: ;
        endcase
    end

    // Drive one cycle of inputs, then move to the next falling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic [1:0] mode,
                                 input logic [3:0] lut, input logic [WW-1:0] a,
                                 input logic [WW-1:0] b, input logic [WW-1:0] as);
        in_valid       = v;
        stall          = s;
        op_mode        = mode;
        op_lut         = lut;
        A              = a;
        B              = b;
        result_add_sub = as;
        @(negedge clock);
    endtask

    // Wait (bounded) for the next valid output and compare it to fixed values.
    task automatic checkOutput(input string name, input logic [WW-1:0] exp_r,
                               input logic [NL-1:0] exp_f);
        bit found;
        found    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (out_valid) begin
                found = 1'b1;
                compare(name, pk(1'b1, zero_flags, R), pk(1'b1, exp_f, exp_r));
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL %s actual=timeout required=out_valid", name);
        end
    endtask

    initial begin
        int            pulses;
        int            first_idx;
        int            seen_cnt;
        logic [WW-1:0] seen [4];
        logic [WW-1:0] ra;
        logic [WW-1:0] rb;
        logic [WW-1:0] rs;

        reset_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; op_mode = 2'b00; op_lut = 4'h0;
        A = '0; B = '0; result_add_sub = '0;
        @(negedge clock);
        @(negedge clock);
        compare("init_reset", pk(out_valid, zero_flags, R), pk(1'b0, '0, '0));
        reset_n = 1'b1;

        // LUT XOR and AND on fixed operands.
        applyStimulus(1'b1, 1'b0, 2'b00, 4'b0110, 36'hF0F0F0F0F, 36'hFF00FF00F, '0);
        checkOutput("lut_xor", 36'h0FF00FF00, 4'b0000);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'b1000, 36'hF0F0F0F0F, 36'hFF00FF00F, '0);
        checkOutput("lut_and", 36'hF000F000F, 4'b0000);

        // Back-to-back PASS_A: four results on consecutive cycles after D-1 edges.
        pulses = 0; first_idx = -1; seen_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 4); stall = 1'b0; op_mode = 2'b10; A = WW'(i + 1);
            @(negedge clock);
            if (out_valid) begin
                if (first_idx < 0) first_idx = i;
                if (seen_cnt < 4) seen[seen_cnt] = R;
                seen_cnt++;
            end
        end
        compare("tput_count", 64'(seen_cnt), 64'd4);
        compare("tput_latency", 64'(first_idx), 64'(D - 1));
        for (int j = 0; j < 4 && j < seen_cnt; j++) begin
            compare("tput_value", 64'(seen[j]), 64'(j + 1));
        end

        // Stall while A=5 sits in stage 2; inputs offered during stall are dropped.
        applyStimulus(1'b1, 1'b0, 2'b10, 4'h0, 36'd5, '0, '0);
        applyStimulus(1'b1, 1'b0, 2'b10, 4'h0, 36'd6, '0, '0);
        applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 36'd99, '0, '0);
        applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 36'd98, '0, '0);
        checkOutput("stall_first", 36'd5, 4'b1110);
        @(negedge clock);
        compare("stall_second", pk(out_valid, zero_flags, R), pk(1'b1, 4'b1110, 36'd6));

        // Popcount per lane with one empty lane.
        applyStimulus(1'b1, 1'b0, 2'b11, 4'h0, {9'd511, 9'd0, 9'd3, 9'd257}, '1, '0);
        checkOutput("popcnt", {9'd9, 9'd0, 9'd2, 9'd2}, 4'b0100);

        // Bubbles: one valid A=7, then invalid A=9; R holds 7, one pulse.
        applyStimulus(1'b1, 1'b0, 2'b10, 4'h0, 36'd7, '0, '0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0; A = 36'd9;
            @(negedge clock);
            if (out_valid) pulses++;
        end
        compare("bubble_pulses", 64'(pulses), 64'd1);
        compare("bubble_r", 64'(R), 64'd7);

        // ADD_SUB pass-through of all ones.
        applyStimulus(1'b1, 1'b0, 2'b01, 4'h0, '0, '0, 36'hFFFFFFFFF);
        checkOutput("add_sub", 36'hFFFFFFFFF, 4'b0000);

        // Reset while stalled with data in flight; nothing stale afterwards.
        applyStimulus(1'b1, 1'b0, 2'b10, 4'h0, 36'h55, '0, '0);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, '0, '0, '0);
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, '0, '0, '0);
        reset_n = 1'b1;
        compare("stall_reset", pk(out_valid, zero_flags, R), pk(1'b0, '0, '0));
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0; stall = 1'b0;
            @(negedge clock);
            if (out_valid) pulses++;
        end
        compare("no_stale", 64'(pulses), 64'd0);

        // Randomized traffic with stalls and rare resets.
        for (int i = 0; i < 400; i++) begin
            ra = WW'({$urandom(), $urandom()});
            rb = WW'({$urandom(), $urandom()});
            rs = WW'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) ra[$urandom_range(0, NL - 1)*LW +: LW] = '0;
            if ($urandom_range(0, 7) == 0) ra = '0;
            reset_n = ($urandom_range(0, 99) != 0);
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 6) == 0,
                          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ra, rb, rs);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, '0, '0, '0);
        end
        compare("drain_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
